// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex; master = producer/consumer side, slave = FIFO.
// Carries o_overflow/o_underflow only when FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_flex_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32
);
   logic                           i_wr_en;
   logic [DATA_WIDTH-1:0]          i_data;
   logic                           i_rd_en;
   logic [DATA_WIDTH-1:0]          o_data;
   logic                           o_rd_valid;
   logic                           o_empty;
   logic                           o_full;
   logic                           o_almost_empty;
   logic                           o_almost_full;
   logic [$clog2(DEPTH+1)-1:0]     o_count;
`ifdef FIFO_ERR_FLAGS_EN
   logic                           o_overflow;
   logic                           o_underflow;

   modport master (
      output i_wr_en, i_data, i_rd_en,
      input  o_data, o_rd_valid, o_empty, o_full, o_almost_empty, o_almost_full, o_count,
             o_overflow, o_underflow
   );

   modport slave (
      input  i_wr_en, i_data, i_rd_en,
      output o_data, o_rd_valid, o_empty, o_full, o_almost_empty, o_almost_full, o_count,
             o_overflow, o_underflow
   );
`else
   modport master (
      output i_wr_en, i_data, i_rd_en,
      input  o_data, o_rd_valid, o_empty, o_full, o_almost_empty, o_almost_full, o_count
   );

   modport slave (
      input  i_wr_en, i_data, i_rd_en,
      output o_data, o_rd_valid, o_empty, o_full, o_almost_empty, o_almost_full, o_count
   );
`endif
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of any depth with occupancy count, almost-full/empty flags and optional FWFT read.
// Sticky o_overflow/o_underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_flex #(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 32,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input logic             i_clk,
   input logic             i_rst,
   sync_fifo_flex_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_T     = CNT_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0] AE_T     = CNT_W'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  empty_q, full_q, aempty_q, afull_q;
   logic                  rdAcc, wrAcc;

   // Wrap by explicit compare so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      rdAcc   = bus.i_rd_en & ~empty_q;
      wrAcc   = bus.i_wr_en & (~full_q | rdAcc);
      count_d = count_q;
      if (wrAcc && !rdAcc) begin
         count_d = count_q + 1'b1;
      end else if (rdAcc && !wrAcc) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wrAcc && !i_rst) begin
         mem[wrPtr_q] <= bus.i_data;
      end
   end

   // Flags are computed from the next count so they line up with o_count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
      end else begin
         if (wrAcc) wrPtr_q <= incPtr(wrPtr_q);
         if (rdAcc) rdPtr_q <= incPtr(rdPtr_q);
         count_q  <= count_d;
         empty_q  <= (count_d == '0);
         full_q   <= (count_d == DEPTH_C);
         aempty_q <= (count_d <= AE_T);
         afull_q  <= (count_d >= AF_T);
      end
   end

   assign bus.o_empty        = empty_q;
   assign bus.o_full         = full_q;
   assign bus.o_almost_empty = aempty_q;
   assign bus.o_almost_full  = afull_q;
   assign bus.o_count        = count_q;

   generate
      if (FWFT != 0) begin : gFwft
         assign bus.o_data     = mem[rdPtr_q];
         assign bus.o_rd_valid = ~empty_q;
      end else begin : gStd
         logic [DATA_WIDTH-1:0] data_q;
         logic                  rdValid_q;

         // Registered read; the old word wins when a full FIFO reads and writes the same slot.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               data_q    <= '0;
               rdValid_q <= 1'b0;
            end else begin
               rdValid_q <= rdAcc;
               if (rdAcc) data_q <= mem[rdPtr_q];
            end
         end

         assign bus.o_data     = data_q;
         assign bus.o_rd_valid = rdValid_q;
      end
   endgenerate

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.i_wr_en && !wrAcc)             overflow_q  <= 1'b1;
         if (bus.i_rd_en && !rdAcc && empty_q) underflow_q <= 1'b1;
      end
   end

   assign bus.o_overflow  = overflow_q;
   assign bus.o_underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: FWFT=0 and FWFT=1 instances share one stimulus stream and one queue model.
// Directed table vectors carry hand-computed expectations; a random phase follows.
module tb_sync_fifo_flex;
   localparam int DW = 16;
   localparam int DP = 6;
   localparam int AF = 5;
   localparam int AE = 1;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;

   sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus0 ();
   sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus1 ();

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(0))
      dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(1))
      dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: contents as a queue, plus the last popped word for the registered-read instance.
   logic [DW-1:0] mq [$];
   logic [DW-1:0] mData0;
   logic          mValid0;
   logic          mOvf, mUnf;

   typedef struct {
      int rst, wr, rd, din;
      int cnt, e, f, ae, af, v, d;
      int fchk, fv, fd;
   } vec_t;
   vec_t vecs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelStep(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
      logic rdAcc, wrAcc;
      if (r) begin
         mq.delete();
         mData0  = '0;
         mValid0 = 1'b0;
         mOvf    = 1'b0;
         mUnf    = 1'b0;
      end else begin
         rdAcc = rd && (mq.size() != 0);
         wrAcc = w && ((mq.size() < DP) || rdAcc);
         if (w && !wrAcc) mOvf = 1'b1;
         if (rd && !rdAcc) mUnf = 1'b1;
         mValid0 = rdAcc;
         if (rdAcc) mData0 = mq.pop_front();
         if (wrAcc) mq.push_back(d);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
      rst          = r;
      bus0.i_wr_en = w;
      bus0.i_rd_en = rd;
      bus0.i_data  = d;
      bus1.i_wr_en = w;
      bus1.i_rd_en = rd;
      bus1.i_data  = d;
      @(posedge clk);
      #1;
      modelStep(r, w, rd, d);
   endtask

   task automatic checkOutput(input string tag);
      int n;
      n = mq.size();
      chk({tag, ".count0"}, 32'(bus0.o_count), 32'(n));
      chk({tag, ".empty0"}, 32'(bus0.o_empty), 32'(n == 0));
      chk({tag, ".full0"}, 32'(bus0.o_full), 32'(n == DP));
      chk({tag, ".aempty0"}, 32'(bus0.o_almost_empty), 32'(n <= AE));
      chk({tag, ".afull0"}, 32'(bus0.o_almost_full), 32'(n >= AF));
      chk({tag, ".valid0"}, 32'(bus0.o_rd_valid), 32'(mValid0));
      chk({tag, ".data0"}, 32'(bus0.o_data), 32'(mData0));
      chk({tag, ".count1"}, 32'(bus1.o_count), 32'(n));
      chk({tag, ".full1"}, 32'(bus1.o_full), 32'(n == DP));
      chk({tag, ".valid1"}, 32'(bus1.o_rd_valid), 32'(n != 0));
      if (n != 0) chk({tag, ".data1"}, 32'(bus1.o_data), 32'(mq[0]));
`ifdef FIFO_ERR_FLAGS_EN
      chk({tag, ".ovf0"}, 32'(bus0.o_overflow), 32'(mOvf));
      chk({tag, ".unf0"}, 32'(bus0.o_underflow), 32'(mUnf));
      chk({tag, ".ovf1"}, 32'(bus1.o_overflow), 32'(mOvf));
      chk({tag, ".unf1"}, 32'(bus1.o_underflow), 32'(mUnf));
`endif
   endtask

   task automatic addVec(input int r, input int w, input int rd, input int din,
                         input int cnt, input int e, input int f, input int ae, input int af,
                         input int v, input int d, input int fchk, input int fv, input int fd);
      vec_t x;
      x.rst = r;   x.wr = w;   x.rd = rd;   x.din = din;
      x.cnt = cnt; x.e = e;    x.f = f;     x.ae = ae;    x.af = af;
      x.v = v;     x.d = d;    x.fchk = fchk; x.fv = fv;  x.fd = fd;
      vecs.push_back(x);
   endtask

   initial begin
      logic          r, w, rd;
      logic [DW-1:0] d;
      int            wrPct;

      testsRun    = 0;
      testsFailed = 0;
      mq.delete();
      mData0  = '0;
      mValid0 = 1'b0;
      mOvf    = 1'b0;
      mUnf    = 1'b0;
      rst = 1'b1;
      bus0.i_wr_en = 1'b0; bus0.i_rd_en = 1'b0; bus0.i_data = '0;
      bus1.i_wr_en = 1'b0; bus1.i_rd_en = 1'b0; bus1.i_data = '0;

      //     rst wr rd din      cnt e f ae af  v  d       fchk fv fd
      addVec(1, 0, 0, 'h0000,   0, 1, 0, 1, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 0, 1, 'h0000,   0, 1, 0, 1, 0, 0, 'h0000, 1, 0, 'h0000);
      addVec(0, 0, 0, 'h0000,   0, 1, 0, 1, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0001,   1, 0, 0, 1, 0, 0, 'h0000, 1, 1, 'h0001);
      addVec(0, 1, 0, 'h0002,   2, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0003,   3, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0004,   4, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0005,   5, 0, 0, 0, 1, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0006,   6, 0, 1, 0, 1, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'hBEEF,   6, 0, 1, 0, 1, 0, 'h0000, 1, 1, 'h0001);
      addVec(0, 0, 1, 'h0000,   5, 0, 0, 0, 1, 1, 'h0001, 1, 1, 'h0002);
      addVec(0, 0, 1, 'h0000,   4, 0, 0, 0, 0, 1, 'h0002, 1, 1, 'h0003);
      addVec(0, 0, 1, 'h0000,   3, 0, 0, 0, 0, 1, 'h0003, 0, 0, 'h0000);
      addVec(0, 0, 1, 'h0000,   2, 0, 0, 0, 0, 1, 'h0004, 0, 0, 'h0000);
      addVec(0, 0, 1, 'h0000,   1, 0, 0, 1, 0, 1, 'h0005, 1, 1, 'h0006);
      addVec(0, 0, 1, 'h0000,   0, 1, 0, 1, 0, 1, 'h0006, 1, 0, 'h0000);
      addVec(0, 0, 0, 'h0000,   0, 1, 0, 1, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h00AA,   1, 0, 0, 1, 0, 0, 'h0000, 1, 1, 'h00AA);
      addVec(0, 0, 1, 'h0000,   0, 1, 0, 1, 0, 1, 'h00AA, 1, 0, 'h0000);
      addVec(0, 1, 0, 'h0001,   1, 0, 0, 1, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0002,   2, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0003,   3, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0004,   4, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0005,   5, 0, 0, 0, 1, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0006,   6, 0, 1, 0, 1, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 1, 'h0100,   6, 0, 1, 0, 1, 1, 'h0001, 1, 1, 'h0002);
      addVec(0, 1, 1, 'h0101,   6, 0, 1, 0, 1, 1, 'h0002, 0, 0, 'h0000);
      addVec(0, 1, 1, 'h0102,   6, 0, 1, 0, 1, 1, 'h0003, 0, 0, 'h0000);
      addVec(0, 1, 1, 'h0103,   6, 0, 1, 0, 1, 1, 'h0004, 1, 1, 'h0005);
      addVec(0, 0, 1, 'h0000,   5, 0, 0, 0, 1, 1, 'h0005, 0, 0, 'h0000);
      addVec(0, 0, 1, 'h0000,   4, 0, 0, 0, 0, 1, 'h0006, 1, 1, 'h0100);
      addVec(0, 0, 1, 'h0000,   3, 0, 0, 0, 0, 1, 'h0100, 0, 0, 'h0000);
      addVec(0, 0, 1, 'h0000,   2, 0, 0, 0, 0, 1, 'h0101, 0, 0, 'h0000);
      addVec(0, 0, 1, 'h0000,   1, 0, 0, 1, 0, 1, 'h0102, 1, 1, 'h0103);
      addVec(0, 0, 1, 'h0000,   0, 1, 0, 1, 0, 1, 'h0103, 1, 0, 'h0000);
      addVec(0, 1, 1, 'h1234,   1, 0, 0, 1, 0, 0, 'h0000, 1, 1, 'h1234);
      addVec(0, 1, 0, 'h0001,   2, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0002,   3, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0003,   4, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(1, 1, 0, 'h0004,   0, 1, 0, 1, 0, 0, 'h0000, 1, 0, 'h0000);
      addVec(0, 0, 0, 'h0000,   0, 1, 0, 1, 0, 0, 'h0000, 0, 0, 'h0000);
      addVec(0, 1, 0, 'h0A0A,   1, 0, 0, 1, 0, 0, 'h0000, 1, 1, 'h0A0A);
      addVec(0, 1, 0, 'h0B0B,   2, 0, 0, 0, 0, 0, 'h0000, 1, 1, 'h0A0A);
      addVec(0, 0, 1, 'h0000,   1, 0, 0, 1, 0, 1, 'h0A0A, 1, 1, 'h0B0B);
      addVec(0, 0, 1, 'h0000,   0, 1, 0, 1, 0, 1, 'h0B0B, 1, 0, 'h0000);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst[0], vecs[i].wr[0], vecs[i].rd[0], vecs[i].din[DW-1:0]);
         checkOutput($sformatf("v%0d", i));
         chk($sformatf("v%0d.tcount", i), 32'(bus0.o_count), vecs[i].cnt);
         chk($sformatf("v%0d.tempty", i), 32'(bus0.o_empty), vecs[i].e);
         chk($sformatf("v%0d.tfull", i), 32'(bus0.o_full), vecs[i].f);
         chk($sformatf("v%0d.taempty", i), 32'(bus0.o_almost_empty), vecs[i].ae);
         chk($sformatf("v%0d.tafull", i), 32'(bus0.o_almost_full), vecs[i].af);
         chk($sformatf("v%0d.tvalid", i), 32'(bus0.o_rd_valid), vecs[i].v);
         if (vecs[i].v != 0) chk($sformatf("v%0d.tdata", i), 32'(bus0.o_data), vecs[i].d);
         if (vecs[i].fchk != 0) begin
            chk($sformatf("v%0d.tfvalid", i), 32'(bus1.o_rd_valid), vecs[i].fv);
            if (vecs[i].fv != 0) chk($sformatf("v%0d.tfdata", i), 32'(bus1.o_data), vecs[i].fd);
         end
`ifdef FIFO_ERR_FLAGS_EN
         if (i == 1) chk("v1.tunderflow", 32'(bus0.o_underflow), 32'd1);
         if (i == 9) chk("v9.toverflow", 32'(bus0.o_overflow), 32'd1);
         if (i == 39) chk("v39.toverflow", 32'(bus0.o_overflow), 32'd0);
`endif
      end

      // Alternate write-heavy and read-heavy phases so both full and empty boundaries get exercised.
      for (int i = 0; i < 3000; i++) begin
         wrPct = (((i / 150) % 2) != 0) ? 75 : 25;
         r  = ($urandom_range(0, 199) == 0);
         w  = ($urandom_range(0, 99) < wrPct);
         rd = ($urandom_range(0, 99) < (100 - wrPct));
         d  = 16'($urandom);
         applyStimulus(r, w, rd, d);
         checkOutput($sformatf("r%0d", i));
      end

      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
